// File: rtl/accum_ctrl_if.sv
// Command/status and accumulator-port control bundle for accum_ctrl.
// master = the controller side, slave = the tile issuer / accumulator side.
interface accum_ctrl_if #(
  parameter int unsigned MUL_SIZE = 32,
  parameter int unsigned ROWS_W   = 8
);
  logic                start_i;
  logic [ROWS_W-1:0]   rows_i;
  logic                accumulate_i;
  logic                out_ready_i;
  logic                port2_wr_en_o;
  logic                add_o;
  logic [MUL_SIZE-1:0] accum_addr_mask_o;
  logic [9:0]          addr_wr_o;
  logic                port1_rd_en_o;
  logic [9:0]          addr_rd_o;
  logic                out_valid_o;
  logic                busy_o;
  logic                done_o;

  modport master (
    input  start_i, rows_i, accumulate_i, out_ready_i,
    output port2_wr_en_o, add_o, accum_addr_mask_o, addr_wr_o,
           port1_rd_en_o, addr_rd_o, out_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, rows_i, accumulate_i, out_ready_i,
    input  port2_wr_en_o, add_o, accum_addr_mask_o, addr_wr_o,
           port1_rd_en_o, addr_rd_o, out_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/accum_ctrl.sv
// Accumulator controller: skewed FILL writes from the systolic array, then flow-controlled DRAIN reads.
// Optional ACC_CTRL_DOUBLE_BUF_EN: address bit 7 selects a bank that flips after every tile.
module accum_ctrl #(
  parameter int unsigned MUL_SIZE = 32,
  parameter int unsigned ROWS_W   = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  accum_ctrl_if.master acc
);
  localparam int unsigned CNT_W = ROWS_W + $clog2(MUL_SIZE) + 1;
  localparam logic [6:0]  SKEW  = 7'(MUL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [ROWS_W-1:0]   r_q, r_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic                acc_q, acc_d;
  logic                valid_q;
  logic                rd_en;
  logic                bank;
  logic [CNT_W-1:0]    fill_last;
  logic [MUL_SIZE-1:0] mask;

  assign fill_last = CNT_W'(rows_q) + CNT_W'(MUL_SIZE) - CNT_W'(2);

`ifdef ACC_CTRL_DOUBLE_BUF_EN
  logic bank_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                 bank_q <= 1'b0;
    else if (state_q == DONE)   bank_q <= ~bank_q;
  end
  assign bank = bank_q;
`else
  assign bank = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      rows_q  <= '0;
      acc_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      rows_q  <= rows_d;
      acc_q   <= acc_d;
      valid_q <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    rows_d  = rows_q;
    acc_d   = acc_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc.start_i) begin
          rows_d  = acc.rows_i;
          acc_d   = acc.accumulate_i;
          k_d     = '0;
          r_d     = '0;
          state_d = (acc.rows_i == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (k_q == fill_last) begin
          state_d = DRAIN;
          r_d     = '0;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // r only advances on an issued read, so stalls neither skip nor repeat rows
        rd_en = acc.out_ready_i;
        if (rd_en) begin
          if (r_q == rows_q - ROWS_W'(1)) state_d = DONE;
          else                            r_d     = r_q + ROWS_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane c = MUL_SIZE-1-i sees its N rows during cycles c .. c+N-1 of FILL
  always_comb begin
    mask = '0;
    if (state_q == FILL) begin
      for (int unsigned i = 0; i < MUL_SIZE; i++) begin
        mask[i] = (k_q >= CNT_W'(MUL_SIZE - 1 - i)) &&
                  (k_q <  CNT_W'(MUL_SIZE - 1 - i) + CNT_W'(rows_q));
      end
    end
  end

  assign acc.port2_wr_en_o     = (state_q == FILL);
  assign acc.add_o             = (state_q == FILL) & acc_q;
  assign acc.accum_addr_mask_o = mask;
  assign acc.addr_wr_o         = (state_q == FILL)  ? {2'b00, bank, 7'(k_q) + SKEW} : '0;
  assign acc.port1_rd_en_o     = rd_en;
  assign acc.addr_rd_o         = (state_q == DRAIN) ? {2'b00, bank, 7'(r_q) + SKEW} : '0;
  assign acc.out_valid_o       = valid_q;
  assign acc.busy_o            = (state_q != IDLE);
  assign acc.done_o            = (state_q == DONE);
endmodule

// File: tb/tb_accum_ctrl.sv
// Table-driven bench for accum_ctrl with a lane-skewed accumulator memory model.
module tb_accum_ctrl;
  localparam int unsigned MUL_SIZE = 32;
  localparam int unsigned ROWS_W   = 8;
  localparam int          MAXCYC   = 400;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tb_bank  = 0;

  accum_ctrl_if #(.MUL_SIZE(MUL_SIZE), .ROWS_W(ROWS_W)) acc_if ();

  accum_ctrl #(.MUL_SIZE(MUL_SIZE), .ROWS_W(ROWS_W)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .acc  (acc_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         rows;
    bit         accum;
    logic [7:0] ready_pat;
    bit         poke;
    int         exp_fill;
    int         exp_done;
  } vec_t;

  vec_t vecs [7];
  int   mem_q [2][128][MUL_SIZE];
  int   exp_q [2][128][MUL_SIZE];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int tile_data(input int t, input int j, input int c);
    return t * 7919 + j * 131 + c * 3 + 1;
  endfunction

  function automatic int out_ones();
    return $countones({acc_if.port2_wr_en_o, acc_if.add_o, acc_if.accum_addr_mask_o,
                       acc_if.addr_wr_o, acc_if.port1_rd_en_o, acc_if.addr_rd_o,
                       acc_if.out_valid_o, acc_if.busy_o, acc_if.done_o});
  endfunction

  task automatic run_tile(input int t, input vec_t v);
    int fills, reads, valids, done_at;
    int fill_err, rd_err, vld_err, data_err, busy_err;
    int c, row, b, d, expv, rd_bank, rd_row;
    logic prev_rd;
    logic [MUL_SIZE-1:0] exp_mask;
    fills = 0; reads = 0; valids = 0; done_at = -1;
    fill_err = 0; rd_err = 0; vld_err = 0; data_err = 0; busy_err = 0;
    rd_bank = 0; rd_row = 0; prev_rd = 1'b0;
    acc_if.start_i      = 1'b1;
    acc_if.rows_i       = ROWS_W'(v.rows);
    acc_if.accumulate_i = v.accum;
    for (int cyc = 1; cyc <= MAXCYC && done_at < 0; cyc++) begin
      @(posedge clk_i); #1;
      acc_if.start_i      = v.poke && cyc >= 2 && cyc <= 5;
      acc_if.rows_i       = (v.poke && cyc >= 2 && cyc <= 5) ? 8'd7 : ROWS_W'(v.rows);
      acc_if.accumulate_i = (v.poke && cyc >= 2 && cyc <= 5) ? ~v.accum : v.accum;
      acc_if.out_ready_i  = (cyc > v.exp_fill) ? v.ready_pat[(cyc - v.exp_fill - 1) % 8] : 1'b1;
      #1;
      if (acc_if.port2_wr_en_o) begin
        for (int i = 0; i < MUL_SIZE; i++) begin
          c = MUL_SIZE - 1 - i;
          exp_mask[i] = (fills >= c) && (fills < c + v.rows);
        end
        if (acc_if.accum_addr_mask_o !== exp_mask ||
            acc_if.addr_wr_o !== {2'b00, tb_bank[0], 7'((fills + MUL_SIZE - 1) % 128)} ||
            acc_if.add_o !== v.accum || acc_if.port1_rd_en_o !== 1'b0)
          fill_err++;
        for (int i = 0; i < MUL_SIZE; i++) begin
          if (acc_if.accum_addr_mask_o[i]) begin
            c   = MUL_SIZE - 1 - i;
            row = (int'(acc_if.addr_wr_o[6:0]) - (MUL_SIZE - 1) - c) & 127;
            b   = int'(acc_if.addr_wr_o[7]);
            d   = tile_data(t, fills - c, c);
            mem_q[b][row][c] = acc_if.add_o ? mem_q[b][row][c] + d : d;
          end
        end
        fills++;
      end else if (acc_if.add_o !== 1'b0 || acc_if.accum_addr_mask_o !== '0) begin
        fill_err++;
      end
      if (acc_if.out_valid_o !== prev_rd) vld_err++;
      if (acc_if.out_valid_o === 1'b1 && valids < 128) begin
        for (int ci = 0; ci < MUL_SIZE; ci++) begin
          expv = (v.accum ? exp_q[tb_bank][valids][ci] : 0) + tile_data(t, valids, ci);
          if (mem_q[rd_bank][rd_row][ci] != expv) data_err++;
        end
        valids++;
      end
      if (acc_if.port1_rd_en_o === 1'b1) begin
        if (acc_if.out_ready_i !== 1'b1 ||
            acc_if.addr_rd_o !== {2'b00, tb_bank[0], 7'((reads + MUL_SIZE - 1) % 128)})
          rd_err++;
        rd_bank = int'(acc_if.addr_rd_o[7]);
        rd_row  = (int'(acc_if.addr_rd_o[6:0]) - (MUL_SIZE - 1)) & 127;
        reads++;
      end
      prev_rd = acc_if.port1_rd_en_o;
      if (acc_if.busy_o !== 1'b1) busy_err++;
      if (acc_if.done_o === 1'b1) done_at = cyc;
    end
    acc_if.start_i = 1'b0;
    check($sformatf("t%0d_fill_cycles", t), fills, v.exp_fill);
    check($sformatf("t%0d_fill_ctl_errs", t), fill_err, 0);
    check($sformatf("t%0d_reads", t), reads, v.rows);
    check($sformatf("t%0d_rd_ctl_errs", t), rd_err, 0);
    check($sformatf("t%0d_valid_errs", t), vld_err, 0);
    check($sformatf("t%0d_valid_count", t), valids, v.rows);
    check($sformatf("t%0d_data_errs", t), data_err, 0);
    check($sformatf("t%0d_busy_errs", t), busy_err, 0);
    check($sformatf("t%0d_done_cycle", t), done_at, v.exp_done);
    @(posedge clk_i); #2;
    check($sformatf("t%0d_post_idle_ones", t), out_ones(), 0);
    for (int j = 0; j < v.rows && j < 128; j++)
      for (int ci = 0; ci < MUL_SIZE; ci++)
        exp_q[tb_bank][j][ci] = (v.accum ? exp_q[tb_bank][j][ci] : 0) + tile_data(t, j, ci);
`ifdef ACC_CTRL_DOUBLE_BUF_EN
    tb_bank ^= 1;
`endif
  endtask

  initial begin
    rst_i               = 1'b0;
    acc_if.start_i      = 1'b0;
    acc_if.rows_i       = '0;
    acc_if.accumulate_i = 1'b0;
    acc_if.out_ready_i  = 1'b1;

    vecs[0] = '{4,  1'b0, 8'hFF, 1'b0, 35,  40};
    vecs[1] = '{4,  1'b1, 8'hFF, 1'b0, 35,  40};
    vecs[2] = '{4,  1'b0, 8'hD9, 1'b0, 35,  43};
    vecs[3] = '{0,  1'b0, 8'hFF, 1'b0, 0,   1};
    vecs[4] = '{1,  1'b0, 8'hFF, 1'b1, 32,  34};
    vecs[5] = '{97, 1'b0, 8'hFF, 1'b0, 128, 226};
    vecs[6] = '{10, 1'b1, 8'h55, 1'b0, 41,  61};

    #2;
    check("reset_out_ones", out_ones(), 0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    check("idle_out_ones", out_ones(), 0);

    // Abandon a tile partway through FILL
    acc_if.start_i = 1'b1;
    acc_if.rows_i  = 8'd4;
    @(posedge clk_i); #1;
    acc_if.start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #2;
    check("midfill_wr_en", acc_if.port2_wr_en_o, 1);
    #1;
    rst_i = 1'b0;
    #1;
    check("midfill_rst_out_ones", out_ones(), 0);
    @(posedge clk_i); #2;
    check("rst_held_out_ones", out_ones(), 0);
    @(posedge clk_i); #3;
    rst_i = 1'b1;

    for (int t = 0; t < 7; t++) run_tile(t, vecs[t]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/accum_ctrl.md
ACCUM_CTRL -- requirements
Module: accum_ctrl

Interface
REQ-001 SHALL have parameter MUL_SIZE, default 32, systolic array edge / accumulator lane count.
REQ-002 SHALL have parameter ROWS_W, default 8, width of the tile row-count field.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  start one tile; sampled only in IDLE.
REQ-006 SHALL have port rows_i  input  ROWS_W  rows streamed out of the array for this tile (N), latched on start.
REQ-007 SHALL have port accumulate_i  input  1  1 = add to stored partials, 0 = overwrite; latched on start.
REQ-008 SHALL have port out_ready_i  input  1  downstream can take a drained row next cycle.
REQ-009 SHALL have port port2_wr_en_o / add_o / accum_addr_mask_o / addr_wr_o  output  1/1/MUL_SIZE/10  accumulator write-side controls.
REQ-010 SHALL have port port1_rd_en_o / addr_rd_o  output  1/10  accumulator read-side controls.
REQ-011 SHALL have port out_valid_o  output  1  accumulator data_o holds a valid drained row this cycle.
REQ-012 SHALL have port busy_o / done_o  output  1/1  tile in progress / one-cycle completion pulse.

Function
REQ-013 SHALL implement states IDLE, FILL, DRAIN, DONE; IDLE->FILL on start_i with rows_i!=0; start_i with rows_i==0 SHALL go directly to DONE.
REQ-014 FILL SHALL last exactly N+MUL_SIZE-1 cycles, counter k=0..N+MUL_SIZE-2; port2_wr_en_o=1 every FILL cycle.
REQ-015 In FILL cycle k, mask bit i (lane c=MUL_SIZE-1-i) SHALL be 1 iff c<=k<c+N (diagonal ramp-up/ramp-down skew).
REQ-016 addr_wr_o SHALL equal {bank, k[6:0]} with k+... computed so lane c writes row k-c; i.e. addr_wr_o[6:0]=k+MUL_SIZE-1 modulo 128 offset by bank base.
REQ-017 add_o SHALL equal latched accumulate_i during FILL and 0 elsewhere.
REQ-018 FILL->DRAIN after last FILL cycle; DRAIN SHALL issue N reads, port1_rd_en_o=1 only in cycles where out_ready_i=1, read counter r advancing only on issue.
REQ-019 addr_rd_o[6:0] SHALL be r+MUL_SIZE-1 modulo 128 (matching REQ-016 skew), bit bank as in FILL.
REQ-020 out_valid_o SHALL be port1_rd_en_o delayed one cycle (accumulator read latency 1).
REQ-021 DRAIN->DONE the cycle after the Nth read issues; DONE lasts one cycle with done_o=1, then IDLE.
REQ-022 busy_o SHALL be 1 in FILL, DRAIN, DONE; start_i while busy SHALL be ignored.
REQ-023 Row index arithmetic SHALL be unsigned, wrap modulo 128 within a bank; N>128-MUL_SIZE+1 is unsupported and need not be flagged.
REQ-024 out_ready_i low for any number of cycles SHALL freeze r without losing or duplicating rows.

Reset
REQ-025 On rst_i low, state=IDLE, counters=0, bank=0, and every output SHALL be 0 asynchronously; mid-tile reset abandons the tile with no done_o.
REQ-026 First active edge after rst_i deasserts SHALL be able to accept start_i.

Configuration
REQ-027 Macro ACC_CTRL_DOUBLE_BUF_EN defined: addr bit 7 is a bank bit toggled on each DONE, so consecutive tiles alternate accumulator halves.
REQ-028 Macro ACC_CTRL_DOUBLE_BUF_EN undefined: bank bit held 0, addr bits 9:7 always 0.

Verification
REQ-029 Reset: rst_i low mid-FILL -> all outputs 0 same cycle, state IDLE, no done_o.
REQ-030 MUL_SIZE=32, N=4, accumulate 0, out_ready 1 -> 35 FILL cycles, mask bit31 on k=0..3, bit0 on k=31..34, 4 out_valid pulses, done_o at cycle 35+4+1.
REQ-031 Two back-to-back tiles, same N, accumulate 1 on second -> add_o high through second FILL; drained data equals sum of both tiles (with accumulator model, DOUBLE_BUF undefined).
REQ-032 DRAIN with out_ready_i pattern 1,0,0,1,1,0,1 and N=4 -> exactly 4 reads, addr_rd_o[6:0]=31,32,33,34, no duplicates.
REQ-033 start_i with rows_i=0 -> DONE next cycle, done_o pulse, no write or read enables.
REQ-034 ACC_CTRL_DOUBLE_BUF_EN defined, three tiles -> addr bit 7 = 0,1,0 across tiles.
